// File: rtl/rb_wr_arbiter.sv
// rb_wr_arbiter: shares the single rb write port (wR/wD/RW) between two writeback
// requesters, A (ALU result) and B (memory load). Each port owns a 1-entry holding
// slot with a valid/ready handshake. A round-robin arbiter drains the slots into
// registered one-cycle write strobes.
// Optional feature macro: R0_PROTECT_EN. When defined, grants to register 0 are
// consumed without raising RW, so register 0 stays constant.
module rb_wr_arbiter #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_data,
    output logic             a_ready,
    input  logic             b_req,
    input  logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    b_data,
    output logic             b_ready,
    output logic [AW-1:0]    wR,
    output logic [DW-1:0]    wD,
    output logic             RW,
    output logic [CNT_W-1:0] col_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t          grant;
    logic            a_full;
    logic            b_full;
    logic [AW-1:0]   a_addr_q;
    logic [AW-1:0]   b_addr_q;
    logic [DW-1:0]   a_data_q;
    logic [DW-1:0]   b_data_q;
    logic            last_b;      // 1: port B won the most recent grant
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_data;
    logic            do_write;

    // Ready comes from the slot flag alone, so it never depends on req.
    assign a_ready = ~a_full;
    assign b_ready = ~b_full;

    // Arbitration: pick the grant from the slot flags and the round-robin pointer.
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        grant    = IDLE;
        g_addr   = a_addr_q;
        g_data   = a_data_q;
        do_write = 1'b0;
        if (a_full && b_full) begin
            grant = last_b ? GNT_A : GNT_B;
        end else if (a_full) begin
            grant = GNT_A;
        end else if (b_full) begin
            grant = GNT_B;
        end
        if (grant == GNT_B) begin
            g_addr = b_addr_q;
            g_data = b_data_q;
        end
`ifdef R0_PROTECT_EN
        // A grant to register 0 still drains the slot but never strobes rb.
        do_write = (grant != IDLE) && (g_addr != '0);
`else
        do_write = (grant != IDLE);
`endif
    end

    // Slots, round-robin pointer, registered rb strobes and the collision counter.
    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full   <= 1'b0;
            b_full   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
            last_b   <= 1'b1;
            RW       <= 1'b0;
            wR       <= '0;
            wD       <= '0;
            col_cnt  <= '0;
        end else begin
            // A slot only captures while empty, so it cannot refill on its drain edge.
            if (a_req && !a_full) begin
                a_full   <= 1'b1;
                a_addr_q <= a_addr;
                a_data_q <= a_data;
            end else if (grant == GNT_A) begin
                a_full <= 1'b0;
            end

            if (b_req && !b_full) begin
                b_full   <= 1'b1;
                b_addr_q <= b_addr;
                b_data_q <= b_data;
            end else if (grant == GNT_B) begin
                b_full <= 1'b0;
            end

            if (grant != IDLE) begin
                last_b <= (grant == GNT_B);
            end

            // wR/wD only move together with a strobe, so RW never sees stale data.
            RW <= do_write;
            if (do_write) begin
                wR <= g_addr;
                wD <= g_data;
            end

            if (a_full && b_full && (col_cnt != '1)) begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rb_wr_arbiter.sv
// Testbench for rb_wr_arbiter: directed scenarios plus a randomized run, all
// compared every cycle against a transaction-level reference model of the slots,
// round-robin choice, collision counter and the resulting register bank contents.
module tb_rb_wr_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int DEPTH = 1 << AW;

    logic             clk;
    logic             rst_n;
    logic             a_req;
    logic [AW-1:0]    a_addr;
    logic [DW-1:0]    a_data;
    logic             a_ready;
    logic             b_req;
    logic [AW-1:0]    b_addr;
    logic [DW-1:0]    b_data;
    logic             b_ready;
    logic [AW-1:0]    wR;
    logic [DW-1:0]    wD;
    logic             RW;
    logic [CNT_W-1:0] col_cnt;

    rb_wr_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req   (a_req),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_req   (b_req),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .b_ready (b_ready),
        .wR      (wR),
        .wD      (wD),
        .RW      (RW),
        .col_cnt (col_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_rw  = 0;

    // Reference model state.
    logic          m_af, m_bf, m_last_b, m_rw;
    logic [AW-1:0] m_aa, m_ba, m_wr;
    logic [DW-1:0] m_ad, m_bd, m_wd;
    int            m_col;
    logic [DW-1:0] m_rb  [DEPTH];
    logic [DW-1:0] tb_rb [DEPTH];
    logic          acc_a, acc_b, a_pend, b_pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_af = 1'b0; m_bf = 1'b0; m_last_b = 1'b1; m_rw = 1'b0;
        m_aa = '0; m_ba = '0; m_ad = '0; m_bd = '0;
        m_wr = '0; m_wd = '0; m_col = 0;
        a_pend = 1'b0; b_pend = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".a_ready"}, 64'(a_ready), 64'(!m_af));
        check({tag, ".b_ready"}, 64'(b_ready), 64'(!m_bf));
        check({tag, ".RW"},      64'(RW),      64'(m_rw));
        check({tag, ".wR"},      64'(wR),      64'(m_wr));
        check({tag, ".wD"},      64'(wD),      64'(m_wd));
        check({tag, ".col_cnt"}, 64'(col_cnt), 64'(m_col));
    endtask

    // One clock cycle: drive inputs at the falling edge, advance the model by one
    // rising edge, then compare at the next falling edge.
    task automatic step(input logic ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic br, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        int            g;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        a_req = ar; a_addr = aa; a_data = ad;
        b_req = br; b_addr = ba; b_data = bd;
        acc_a = ar && !m_af;
        acc_b = br && !m_bf;
        g = -1;
        if (m_af && m_bf) g = m_last_b ? 0 : 1;
        else if (m_af)    g = 0;
        else if (m_bf)    g = 1;
        if (m_af && m_bf && m_col < CMAX) m_col++;
        m_rw = 1'b0;
        if (g >= 0) begin
            ga = (g == 0) ? m_aa : m_ba;
            gd = (g == 0) ? m_ad : m_bd;
            m_rw = 1'b1;
`ifdef R0_PROTECT_EN
            if (ga == 0) m_rw = 1'b0;
`endif
            if (m_rw) begin
                m_wr = ga;
                m_wd = gd;
                m_rb[ga] = gd;
            end
            if (g == 0) m_af = 1'b0;
            else        m_bf = 1'b0;
            m_last_b = (g == 1);
        end
        if (acc_a) begin m_af = 1'b1; m_aa = aa; m_ad = ad; end
        if (acc_b) begin m_bf = 1'b1; m_ba = ba; m_bd = bd; end
        a_pend = ar && !acc_a;
        b_pend = br && !acc_b;
        @(posedge clk);
        @(negedge clk);
        check_outputs("cyc");
        if (RW) begin
            tb_rb[wR] = wD;
            n_rw++;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [DW-1:0] a_dat [8];
    logic [DW-1:0] b_dat [8];

    initial begin
        int a_sent, b_sent, prev_port, alt_err, n_pulse, rw0;
        logic          ar, br;
        logic [AW-1:0] aa, ba;
        logic [DW-1:0] ad, bd;

        for (int i = 0; i < DEPTH; i++) begin
            m_rb[i] = '0;
            tb_rb[i] = '0;
        end
        rst_n = 1'b0;
        a_req = 1'b0; a_addr = '0; a_data = '0;
        b_req = 1'b0; b_addr = '0; b_data = '0;
        model_reset();
        @(negedge clk);
        check("reset.a_ready", 64'(a_ready), 64'd1);
        check("reset.b_ready", 64'(b_ready), 64'd1);
        check("reset.RW",      64'(RW),      64'd0);
        check("reset.wR",      64'(wR),      64'd0);
        check("reset.wD",      64'(wD),      64'd0);
        check("reset.col_cnt", 64'(col_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A only: capture, then one strobe with the captured contents.
        step(1'b1, 5'd3, 32'hAAAA_AAAA, 1'b0, '0, '0);
        check("a_only.a_ready_N", 64'(a_ready), 64'd0);
        check("a_only.RW_N",      64'(RW),      64'd0);
        idle();
        check("a_only.RW",      64'(RW),      64'd1);
        check("a_only.wR",      64'(wR),      64'd3);
        check("a_only.wD",      64'(wD),      64'hAAAA_AAAA);
        check("a_only.a_ready", 64'(a_ready), 64'd1);
        idle();
        check("a_only.RW_drop", 64'(RW),      64'd0);
        check("a_only.wD_hold", 64'(wD),      64'hAAAA_AAAA);

        // Register 0 write.
        step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, '0);
        idle();
        check("r0.a_ready", 64'(a_ready), 64'd1);
`ifdef R0_PROTECT_EN
        check("r0.RW", 64'(RW), 64'd0);
        check("r0.wD", 64'(wD), 64'hAAAA_AAAA);
`else
        check("r0.RW", 64'(RW), 64'd1);
        check("r0.wR", 64'(wR), 64'd0);
        check("r0.wD", 64'(wD), 64'hDEAD_BEEF);
`endif
        idle();

        // Simultaneous capture after reset: A first, then B.
        do_reset();
        step(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd10, 32'h2222_2222);
        idle();
        check("tie.first_wR",  64'(wR), 64'd5);
        check("tie.first_wD",  64'(wD), 64'h1111_1111);
        idle();
        check("tie.second_RW", 64'(RW), 64'd1);
        check("tie.second_wR", 64'(wR), 64'd10);
        check("tie.second_wD", 64'(wD), 64'h2222_2222);
        check("tie.col_cnt",   64'(col_cnt), 64'd1);
        idle();

        // Make A the most recent winner, then collide on the same address.
        step(1'b1, 5'd1, 32'h0000_0001, 1'b0, '0, '0);
        idle();
        idle();
        step(1'b1, 5'd15, 32'hFFFF_0000, 1'b1, 5'd15, 32'h0000_FFFF);
        idle();
        check("same.first_wD",  64'(wD), 64'h0000_FFFF);
        idle();
        check("same.second_wD", 64'(wD), 64'hFFFF_0000);
        check("same.rb15",      64'(tb_rb[15]), 64'hFFFF_0000);
        idle();

        // Back-to-back streaming from both ports.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_dat[i] = $urandom;
            b_dat[i] = $urandom;
        end
        a_sent = 0; b_sent = 0; prev_port = -1; alt_err = 0; n_pulse = 0;
        rw0 = n_rw;
        for (int c = 0; c < 40; c++) begin
            ar = (a_sent < 8);
            br = (b_sent < 8);
            aa = AW'(1 + a_sent);
            ba = AW'(16 + b_sent);
            ad = ar ? a_dat[a_sent] : '0;
            bd = br ? b_dat[b_sent] : '0;
            step(ar, aa, ad, br, ba, bd);
            if (acc_a) a_sent++;
            if (acc_b) b_sent++;
            if (RW) begin
                if (n_pulse > 0 && prev_port == int'(wR >= 16)) alt_err++;
                prev_port = int'(wR >= 16);
                n_pulse++;
            end
        end
        check("stream.pulses",      64'(n_rw - rw0), 64'd16);
        check("stream.alternation", 64'(alt_err),    64'd0);
        for (int i = 0; i < 8; i++) begin
            check("stream.rb_a", 64'(tb_rb[1 + i]),  64'(a_dat[i]));
            check("stream.rb_b", 64'(tb_rb[16 + i]), 64'(b_dat[i]));
        end

        // Collision counter saturation.
        do_reset();
        for (int i = 0; i < CMAX + 5; i++) begin
            step(1'b1, AW'($urandom), $urandom, 1'b1, AW'($urandom), $urandom);
            idle();
            idle();
        end
        check("sat.col_cnt", 64'(col_cnt), 64'(CMAX));

        // Asynchronous reset mid-cycle while both slots are full.
        step(1'b1, 5'd7, 32'h7777_7777, 1'b1, 5'd8, 32'h8888_8888);
        check("async.pre_a_ready", 64'(a_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.RW",      64'(RW),      64'd0);
        check("async.a_ready", 64'(a_ready), 64'd1);
        check("async.b_ready", 64'(b_ready), 64'd1);
        check("async.col_cnt", 64'(col_cnt), 64'd0);
        a_req = 1'b0; b_req = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs("async.held");
        rst_n = 1'b1;

        // Randomized traffic; requests are held stable until accepted.
        for (int c = 0; c < 3000; c++) begin
            if (a_pend) begin
                ar = a_req; aa = a_addr; ad = a_data;
            end else begin
                ar = ($urandom_range(0, 99) < 60);
                aa = AW'($urandom);
                ad = $urandom;
            end
            if (b_pend) begin
                br = b_req; ba = b_addr; bd = b_data;
            end else begin
                br = ($urandom_range(0, 99) < 60);
                ba = AW'($urandom);
                bd = $urandom;
            end
            step(ar, aa, ad, br, ba, bd);
        end
        idle();
        idle();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            check("rand.rb", 64'(tb_rb[i]), 64'(m_rb[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
